// File: rtl/four_bit_demux_reg_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package four_bit_demux_reg_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NUM_CH    = 4;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH0 = 2'b00;
  localparam ch_idx_t CH1 = 2'b01;
  localparam ch_idx_t CH2 = 2'b10;
  localparam ch_idx_t CH3 = 2'b11;

endpackage

// File: rtl/four_bit_demux_reg_chan.sv
// One held output channel: a data register plus a flag that says it was written.
// Clear has priority over write; otherwise the channel holds.
module demux_chan_reg
  import four_bit_demux_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             v_q, v_d;

  // Next-state for the channel: clear wins, then write, else hold.
  always_comb begin
    q_d = q_q;
    v_d = v_q;
    if (clr) begin
      q_d = '0;
      v_d = 1'b0;
    end else if (we) begin
      q_d = d;
      v_d = 1'b1;
    end
  end

  // Channel state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
      v_q <= 1'b0;
    end else begin
      q_q <= q_d;
      v_q <= v_d;
    end
  end

  assign q = q_q;
  assign v = v_q;

endmodule

// File: rtl/four_bit_demux_reg.sv
// Registered 1-to-4 demultiplexer. A load writes din into the channel picked by
// sel (direct mode) or by a wrap-around pointer (auto mode), and reports valid
// flags, a full flag, an overwrite pulse and the last written channel.
module four_bit_demux_reg
  import four_bit_demux_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NUM_CH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  input  logic             load,
  input  logic             auto,
  input  logic             clr,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [NCH-1:0]   vld,
  output logic             full,
  output logic             ovr,
  output logic [1:0]       last_ch,
  output logic [1:0]       ptr
);

  ch_idx_t          tgt;
  ch_idx_t          ptr_q, ptr_d;
  ch_idx_t          last_ch_q, last_ch_d;
  logic             ovr_q, ovr_d;
  logic [NCH-1:0]   chan_we;
  logic [WIDTH-1:0] chan_q [NCH];

  // Target decode, pointer advance, overwrite detection and last-channel tracking.
  // The overwrite flag looks at the valid bit before this load sets it.
  always_comb begin
    tgt       = auto ? ptr_q : ch_idx_t'(sel);
    ptr_d     = ptr_q;
    last_ch_d = last_ch_q;
    ovr_d     = 1'b0;
    if (clr) begin
      ptr_d     = CH0;
      last_ch_d = CH0;
    end else if (load) begin
      last_ch_d = tgt;
      ovr_d     = vld[tgt];
      if (auto) begin
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

  // Per-channel write enables; channels themselves give clear priority over write.
  always_comb begin
    chan_we = '0;
    for (int i = 0; i < NCH; i++) begin
      chan_we[i] = load && (tgt == ch_idx_t'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .we  (chan_we[g]),
      .d   (din),
      .q   (chan_q[g]),
      .v   (vld[g])
    );
  end

  // Pointer, last-channel and overwrite registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= CH0;
      last_ch_q <= CH0;
      ovr_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      last_ch_q <= last_ch_d;
      ovr_q     <= ovr_d;
    end
  end

  assign y0      = chan_q[0];
  assign y1      = chan_q[1];
  assign y2      = chan_q[2];
  assign y3      = chan_q[3];
  assign full    = &vld;
  assign ovr     = ovr_q;
  assign last_ch = last_ch_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_four_bit_demux_reg.sv
// Testbench for four_bit_demux_reg: directed vector table, a hand-written
// asynchronous reset sequence, then random traffic against a reference model.
module tb_four_bit_demux_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [1:0] sel;
  logic       load, auto_i, clr;
  logic [3:0] y0, y1, y2, y3, vld;
  logic       full, ovr;
  logic [1:0] last_ch, ptr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] y0, y1, y2, y3, vld;
    logic       full, ovr;
    logic [1:0] last, ptr;
  } outs_t;

  typedef struct {
    logic       load, auto_m, clr;
    logic [1:0] sel;
    logic [3:0] din;
    outs_t      exp;
  } vec_t;

  vec_t vecs[17];

  // Reference model state: channel contents, written flags, pointer as an integer.
  logic [3:0] m_y[4];
  bit         m_vld[4];
  int         m_ptr, m_last;
  bit         m_ovr;

  four_bit_demux_reg dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .load(load), .auto(auto_i),
    .clr(clr), .y0(y0), .y1(y1), .y2(y2), .y3(y3), .vld(vld), .full(full),
    .ovr(ovr), .last_ch(last_ch), .ptr(ptr)
  );

  always #5 clk = ~clk;

  function automatic outs_t mkOut(logic [3:0] a, logic [3:0] b, logic [3:0] c,
                                  logic [3:0] d, logic [3:0] v, logic f, logic o,
                                  logic [1:0] l, logic [1:0] p);
    outs_t r;
    r.y0 = a; r.y1 = b; r.y2 = c; r.y3 = d; r.vld = v;
    r.full = f; r.ovr = o; r.last = l; r.ptr = p;
    return r;
  endfunction

  function automatic vec_t mkVec(logic ld, logic au, logic cl, logic [1:0] s,
                                 logic [3:0] dn, outs_t e);
    vec_t r;
    r.load = ld; r.auto_m = au; r.clr = cl; r.sel = s; r.din = dn; r.exp = e;
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      m_y[i]   = 4'h0;
      m_vld[i] = 1'b0;
    end
    m_ptr  = 0;
    m_last = 0;
    m_ovr  = 1'b0;
  endtask

  task automatic modelStep(logic ld, logic au, logic cl, logic [1:0] s, logic [3:0] dn);
    int t;
    if (cl) begin
      modelReset();
    end else if (ld) begin
      t        = au ? m_ptr : int'(s);
      m_ovr    = m_vld[t];
      m_y[t]   = dn;
      m_vld[t] = 1'b1;
      m_last   = t;
      if (au) m_ptr = (m_ptr + 1) % 4;
    end else begin
      m_ovr = 1'b0;
    end
  endtask

  function automatic outs_t modelOut();
    outs_t r;
    int    nvalid;
    nvalid = 0;
    r.vld  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      r.vld[i] = m_vld[i];
      if (m_vld[i]) nvalid++;
    end
    r.y0 = m_y[0]; r.y1 = m_y[1]; r.y2 = m_y[2]; r.y3 = m_y[3];
    r.full = (nvalid == 4);
    r.ovr  = m_ovr;
    r.last = 2'(m_last);
    r.ptr  = 2'(m_ptr);
    return r;
  endfunction

  task automatic checkField(string tag, string fname, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h expected %h", tag, fname, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, outs_t e);
    checkField(tag, "y0",      8'(y0),      8'(e.y0));
    checkField(tag, "y1",      8'(y1),      8'(e.y1));
    checkField(tag, "y2",      8'(y2),      8'(e.y2));
    checkField(tag, "y3",      8'(y3),      8'(e.y3));
    checkField(tag, "vld",     8'(vld),     8'(e.vld));
    checkField(tag, "full",    8'(full),    8'(e.full));
    checkField(tag, "ovr",     8'(ovr),     8'(e.ovr));
    checkField(tag, "last_ch", 8'(last_ch), 8'(e.last));
    checkField(tag, "ptr",     8'(ptr),     8'(e.ptr));
  endtask

  // Drive one cycle of inputs, advance the model, and settle just after the edge.
  task automatic applyStimulus(logic ld, logic au, logic cl, logic [1:0] s, logic [3:0] dn);
    load = ld; auto_i = au; clr = cl; sel = s; din = dn;
    modelStep(ld, au, cl, s, dn);
    @(posedge clk);
    #1;
  endtask

  initial begin
    outs_t zero;
    zero = mkOut(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0);

    vecs[0]  = mkVec(1, 0, 0, 2'd2, 4'hA, mkOut(4'h0, 4'h0, 4'hA, 4'h0, 4'b0100, 0, 0, 2'd2, 2'd0));
    vecs[1]  = mkVec(0, 0, 1, 2'd0, 4'h0, zero);
    vecs[2]  = mkVec(1, 1, 0, 2'd3, 4'h1, mkOut(4'h1, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 0, 2'd0, 2'd1));
    vecs[3]  = mkVec(1, 1, 0, 2'd0, 4'h2, mkOut(4'h1, 4'h2, 4'h0, 4'h0, 4'b0011, 0, 0, 2'd1, 2'd2));
    vecs[4]  = mkVec(1, 1, 0, 2'd1, 4'h3, mkOut(4'h1, 4'h2, 4'h3, 4'h0, 4'b0111, 0, 0, 2'd2, 2'd3));
    vecs[5]  = mkVec(1, 1, 0, 2'd2, 4'h4, mkOut(4'h1, 4'h2, 4'h3, 4'h4, 4'b1111, 1, 0, 2'd3, 2'd0));
    vecs[6]  = mkVec(1, 1, 0, 2'd3, 4'hF, mkOut(4'hF, 4'h2, 4'h3, 4'h4, 4'b1111, 1, 1, 2'd0, 2'd1));
    vecs[7]  = mkVec(0, 1, 0, 2'd0, 4'h0, mkOut(4'hF, 4'h2, 4'h3, 4'h4, 4'b1111, 1, 0, 2'd0, 2'd1));
    vecs[8]  = mkVec(0, 0, 1, 2'd0, 4'h0, zero);
    vecs[9]  = mkVec(1, 1, 0, 2'd2, 4'h5, mkOut(4'h5, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 0, 2'd0, 2'd1));
    vecs[10] = mkVec(1, 0, 0, 2'd3, 4'h6, mkOut(4'h5, 4'h0, 4'h0, 4'h6, 4'b1001, 0, 0, 2'd3, 2'd1));
    vecs[11] = mkVec(1, 1, 0, 2'd0, 4'h7, mkOut(4'h5, 4'h7, 4'h0, 4'h6, 4'b1011, 0, 0, 2'd1, 2'd2));
    vecs[12] = mkVec(1, 0, 1, 2'd0, 4'h9, zero);
    vecs[13] = mkVec(1, 0, 0, 2'd0, 4'h9, mkOut(4'h9, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 0, 2'd0, 2'd0));
    vecs[14] = mkVec(1, 0, 0, 2'd0, 4'h8, mkOut(4'h8, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 1, 2'd0, 2'd0));
    vecs[15] = mkVec(1, 0, 0, 2'd0, 4'h7, mkOut(4'h7, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 1, 2'd0, 2'd0));
    vecs[16] = mkVec(0, 0, 0, 2'd0, 4'h0, mkOut(4'h7, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 0, 2'd0, 2'd0));

    rst = 1'b1; load = 1'b0; auto_i = 1'b0; clr = 1'b0; sel = 2'd0; din = 4'h0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", zero);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].load, vecs[i].auto_m, vecs[i].clr, vecs[i].sel, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(0, 0, 1, 2'd0, 4'h0);
    applyStimulus(1, 1, 0, 2'd0, 4'h3);
    applyStimulus(1, 1, 0, 2'd0, 4'h5);
    checkOutput("prefill", mkOut(4'h3, 4'h5, 4'h0, 4'h0, 4'b0011, 0, 0, 2'd1, 2'd2));
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", zero);
    #1 rst = 1'b0;
    modelReset();
    applyStimulus(1, 0, 0, 2'd1, 4'hC);
    checkOutput("post_rst", mkOut(4'h0, 4'hC, 4'h0, 4'h0, 4'b0010, 0, 0, 2'd1, 2'd0));

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) < 70, 1'($urandom), $urandom_range(0, 99) < 5,
                    2'($urandom), 4'($urandom));
      checkOutput($sformatf("rand%0d", n), modelOut());
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        modelReset();
        #1 checkOutput($sformatf("rand_rst%0d", n), modelOut());
        #1 rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
